// File: rtl/udp_port_filter_pkg.sv
// udp_port_filter_pkg: FSM states, header constants and byte offsets shared by the UDP port filter.
package udp_port_filter_pkg;
   typedef enum logic [1:0] {IDLE, HDR, FWD, DROP} state_t;
   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
   localparam logic [7:0] IP_VER_IHL = 8'h45;
   localparam logic [7:0] IP_PROTO_UDP = 8'h11;
   localparam int OFF_ETH_TYPE = 12;
   localparam int OFF_IP_VER = 14;
   localparam int OFF_IP_PROTO = 23;
   localparam int OFF_UDP_DST = 36;
   localparam int BEAT_BYTES = 32;
   function automatic logic [7:0] byte_at(input logic [255:0] d, input int idx);
      return d[8*idx +: 8];
   endfunction
endpackage

// File: rtl/udp_port_filter_if.sv
// udp_port_filter_if: AXI-Stream bundle with master/slave views.
interface udp_port_filter_if #(
   parameter int DW = 256,
   parameter int UW = 128
);
   logic [DW-1:0] tdata;
   logic [DW/8-1:0] tkeep;
   logic [UW-1:0] tuser;
   logic tvalid;
   logic tready;
   logic tlast;
   modport master(output tdata, tkeep, tuser, tvalid, tlast, input tready);
   modport slave(input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/udp_port_filter_hdr_match.sv
// udp_hdr_match: combinational IPv4/UDP header test over beat 0 and beat 1 of a frame.
module udp_hdr_match
   import udp_port_filter_pkg::*;
#(
   parameter logic [15:0] UDP_DST_PORT = 16'd2000
) (
   input logic [255:0] beat0,
   input logic [255:0] beat1,
   output logic match
);
   // The destination port straddles into beat 1, so its offset is rebased by one beat.
   assign match = {byte_at(beat0, OFF_ETH_TYPE), byte_at(beat0, OFF_ETH_TYPE + 1)} == ETH_TYPE_IPV4
      && byte_at(beat0, OFF_IP_VER) == IP_VER_IHL
      && byte_at(beat0, OFF_IP_PROTO) == IP_PROTO_UDP
      && {byte_at(beat1, OFF_UDP_DST - BEAT_BYTES), byte_at(beat1, OFF_UDP_DST - BEAT_BYTES + 1)} == UDP_DST_PORT;
endmodule

// File: rtl/udp_port_filter.sv
// udp_port_filter: forwards IPv4/UDP frames addressed to one destination port, drops the rest.
// Beat 0 waits in a hold register until beat 1 arrives and the decision can be made.
module udp_port_filter
   import udp_port_filter_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter logic [15:0] UDP_DST_PORT = 16'd2000
) (
   input logic axis_aclk,
   input logic axis_reset,
   udp_port_filter_if.slave s_axis,
   udp_port_filter_if.master m_axis,
   output logic [31:0] pass_count,
   output logic [31:0] drop_count
);
   state_t state, state_nx;
   logic [C_S_AXIS_DATA_WIDTH-1:0] h_data;
   logic [C_S_AXIS_DATA_WIDTH/8-1:0] h_keep;
   logic [C_S_AXIS_TUSER_WIDTH-1:0] h_user;
   logic h_last, h_valid;
   logic out_free, accept, match, decide, h_load, o_load, runt;

   udp_hdr_match #(.UDP_DST_PORT(UDP_DST_PORT)) u_match (
      .beat0(h_data),
      .beat1(s_axis.tdata),
      .match(match)
   );

   assign out_free = !m_axis.tvalid || m_axis.tready;
   // In FWD, intake pauses once the frame's last beat sits in H so the next frame starts cleanly in IDLE.
   assign s_axis.tready = !axis_reset && (state == IDLE || state == DROP
      || (out_free && !(state == FWD && h_valid && h_last)));
   assign accept = s_axis.tvalid && s_axis.tready;
   assign decide = state == HDR && accept;
   assign runt = state == IDLE && accept && s_axis.tlast;
   assign h_load = accept && (state == IDLE || state == FWD || (state == HDR && match));
   assign o_load = (state == FWD && out_free) || (decide && match);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = accept && !s_axis.tlast ? HDR : IDLE;
         HDR: state_nx = !accept ? HDR : match ? FWD : s_axis.tlast ? IDLE : DROP;
         FWD: state_nx = out_free && h_valid && h_last ? IDLE : FWD;
         DROP: state_nx = accept && s_axis.tlast ? IDLE : DROP;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge axis_aclk) begin
      if (axis_reset) begin
         state <= IDLE;
         h_valid <= 1'b0;
         h_last <= 1'b0;
         h_data <= '0;
         h_keep <= '0;
         h_user <= '0;
         m_axis.tvalid <= 1'b0;
         m_axis.tlast <= 1'b0;
         m_axis.tdata <= '0;
         m_axis.tkeep <= '0;
         m_axis.tuser <= '0;
         pass_count <= '0;
         drop_count <= '0;
      end else begin
         state <= state_nx;
         h_valid <= state == IDLE ? accept && !s_axis.tlast
            : state == HDR ? (accept ? match : h_valid)
            : state == FWD ? (out_free ? accept : h_valid) : 1'b0;
         if (h_load) begin
            h_data <= s_axis.tdata;
            h_keep <= s_axis.tkeep;
            h_user <= s_axis.tuser;
            h_last <= s_axis.tlast;
         end
         if (o_load) begin
            m_axis.tvalid <= h_valid;
            m_axis.tdata <= h_data;
            m_axis.tkeep <= h_keep;
            m_axis.tuser <= h_user;
            m_axis.tlast <= h_last;
         end else if (m_axis.tready) begin
            m_axis.tvalid <= 1'b0;
         end
         pass_count <= pass_count + {31'd0, decide && match};
         drop_count <= drop_count + {31'd0, (decide && !match) || runt};
      end
   end
endmodule

// File: tb/tb_udp_port_filter.sv
// tb_udp_port_filter: directed scenarios plus random frames checked against a frame-level reference model.
module tb_udp_port_filter;
   typedef struct packed {
      logic [255:0] data;
      logic [31:0] keep;
      logic [127:0] user;
      logic last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_q = 1'b0;
   logic [31:0] pass_count, drop_count;
   udp_port_filter_if #(.DW(256), .UW(128)) s_if ();
   udp_port_filter_if #(.DW(256), .UW(128)) m_if ();

   udp_port_filter dut (
      .axis_aclk(clk),
      .axis_reset(rst),
      .s_axis(s_if),
      .m_axis(m_if),
      .pass_count(pass_count),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rst_q <= rst;

   int tests = 0;
   int fails = 0;
   beat_t exp_q[$];
   beat_t frame[$];
   logic [31:0] exp_pass = 0, exp_drop = 0;
   logic [7:0] fb[0:255];
   int flen;
   logic gaps = 1'b0, rand_rdy = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Output monitor: every handshake must pop the model queue; a stalled beat must not change.
   beat_t prev;
   logic prev_stall = 1'b0;
   always @(negedge clk) begin
      beat_t cur, e;
      cur = {m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast};
      if (rst && rst_q) begin
         tests++;
         assert ({m_if.tvalid, cur, s_if.tready, pass_count, drop_count} === '0) else begin
            fails++;
            $error("FAIL reset_outputs observed valid=%b beat=%h rdy=%b pass=%0d drop=%0d expected all zero",
                   m_if.tvalid, cur, s_if.tready, pass_count, drop_count);
         end
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            tests++;
            assert ({m_if.tvalid, cur} === {1'b1, prev}) else begin
               fails++;
               $error("FAIL stall_stable observed=%b/%h expected=1/%h", m_if.tvalid, cur, prev);
            end
         end
         if (m_if.tvalid && m_if.tready) begin
            tests++;
            assert (exp_q.size() > 0) else begin
               fails++;
               $error("FAIL out_extra observed=%h expected=no beat", cur);
            end
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               tests++;
               assert (cur === e) else begin
                  fails++;
                  $error("FAIL out_beat observed=%h expected=%h", cur, e);
               end
            end
         end
         prev_stall = m_if.tvalid && !m_if.tready;
         prev = cur;
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) m_if.tready = $urandom_range(0, 2) != 0;
   end

   // mode 0 builds a valid IPv4/UDP header; modes 1..4 break exactly one header field.
   task automatic make_frame(input int len, input logic [15:0] port, input int mode);
      for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
      fb[12] = 8'h08;
      fb[13] = 8'h00;
      fb[14] = 8'h45;
      fb[23] = 8'h11;
      if (mode == 1) fb[12] = 8'h86;
      if (mode == 2) fb[13] = 8'h06;
      if (mode == 3) fb[14] = 8'h46;
      if (mode == 4) fb[23] = 8'h06;
      fb[36] = port[15:8];
      fb[37] = port[7:0];
      flen = len;
   endtask

   task automatic build_frame(input bit model);
      int nb;
      bit m;
      beat_t b;
      nb = (flen + 31) / 32;
      frame.delete();
      for (int k = 0; k < nb; k++) begin
         for (int j = 0; j < 32; j++) b.data[8*j +: 8] = fb[32*k + j];
         b.keep = (k == nb - 1 && flen % 32 != 0) ? (32'h1 << (flen % 32)) - 32'h1 : '1;
         b.user = {$urandom, $urandom, $urandom, $urandom};
         b.last = k == nb - 1;
         frame.push_back(b);
      end
      m = nb >= 2 && fb[12] == 8'h08 && fb[13] == 8'h00 && fb[14] == 8'h45 && fb[23] == 8'h11
          && {fb[36], fb[37]} == 16'd2000;
      if (model) begin
         if (m) begin
            foreach (frame[k]) exp_q.push_back(frame[k]);
            exp_pass++;
         end else exp_drop++;
      end
   endtask

   task automatic drive_beat(input beat_t b);
      if (gaps && $urandom_range(0, 3) == 0) begin
         s_if.tvalid = 1'b0;
         repeat ($urandom_range(1, 2)) @(posedge clk);
         #1;
      end
      s_if.tvalid = 1'b1;
      s_if.tdata = b.data;
      s_if.tkeep = b.keep;
      s_if.tuser = b.user;
      s_if.tlast = b.last;
      for (int c = 0; ; c++) begin
         @(negedge clk);
         if (s_if.tready) break;
         if (c > 300) begin
            $display("FAIL in_accept_timeout observed=tready low expected=accept within 300 cycles");
            $fatal(1, "input stalled");
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame();
      foreach (frame[k]) drive_beat(frame[k]);
      s_if.tvalid = 1'b0;
      s_if.tlast = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !m_if.tvalid) break;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
      check({tag, "_pass"}, pass_count, exp_pass);
      check({tag, "_drop"}, drop_count, exp_drop);
      @(posedge clk);
      #1;
   endtask

   initial begin
      s_if.tvalid = 1'b0;
      s_if.tdata = '0;
      s_if.tkeep = '0;
      s_if.tuser = '0;
      s_if.tlast = 1'b0;
      m_if.tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_pass", pass_count, 0);
      check("rst_drop", drop_count, 0);
      check("rst_tvalid", {31'd0, m_if.tvalid}, 0);
      // 42-byte frame to the filtered port: first output one cycle after beat 1.
      make_frame(42, 16'd2000, 0);
      build_frame(1);
      send_frame();
      check("s1_first_valid", {31'd0, m_if.tvalid}, 1);
      check("s1_first_data", m_if.tdata[31:0], frame[0].data[31:0]);
      drain("s1");
      make_frame(42, 16'd2001, 0);
      build_frame(1);
      send_frame();
      drain("s2");
      make_frame(16, 16'd2000, 0);
      build_frame(1);
      send_frame();
      drain("s3");
      // 4-beat match with the sink stalled for 5 cycles once the first beat appears.
      m_if.tready = 1'b0;
      make_frame(120, 16'd2000, 0);
      build_frame(1);
      fork
         send_frame();
         begin
            for (int c = 0; c < 100 && !m_if.tvalid; c++) @(negedge clk);
            check("s4_first_valid", {31'd0, m_if.tvalid}, 1);
            repeat (5) @(posedge clk);
            #1;
            m_if.tready = 1'b1;
         end
      join
      drain("s4");
      // Reset while beat 2 is offered; beat 0 already left, the rest is abandoned.
      make_frame(120, 16'd2000, 0);
      build_frame(0);
      exp_q.push_back(frame[0]);
      drive_beat(frame[0]);
      drive_beat(frame[1]);
      s_if.tvalid = 1'b1;
      s_if.tdata = frame[2].data;
      s_if.tkeep = frame[2].keep;
      s_if.tuser = frame[2].user;
      s_if.tlast = frame[2].last;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      s_if.tvalid = 1'b0;
      exp_pass = 0;
      exp_drop = 0;
      check("s5_partial_out", exp_q.size(), 0);
      make_frame(70, 16'd2000, 0);
      build_frame(1);
      send_frame();
      drain("s5");
      check("s5_pass_one", pass_count, 1);
      for (int f = 0; f < 3; f++) begin
         make_frame(50, f == 1 ? 16'd7 : 16'd2000, 0);
         build_frame(1);
         send_frame();
      end
      drain("s6");
      // Header field corruptions, random lengths, input gaps and random sink backpressure.
      gaps = 1'b1;
      rand_rdy = 1'b1;
      for (int f = 0; f < 30; f++) begin
         make_frame($urandom_range(16, 140), $urandom_range(0, 1) ? 16'd2000 : 16'($urandom_range(1999, 2001)),
                    $urandom_range(0, 4));
         build_frame(1);
         send_frame();
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      #1;
      m_if.tready = 1'b1;
      drain("rand");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
